decoder_scan_ctrl: RTL

Upstream driver for the 2-to-4 decoder: generates the `EN`, `A1` and `A0` inputs so that the decoder outputs D0–D3 are selected in round-robin order. Each enabled channel is held for a programmable dwell time, and masked channels are skipped. The block runs either continuously or for a single rotation. Its outputs connect directly to the decoder's `EN`, `A1` and `A0` ports.

---
 rtl/decoder_scan_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: round-robin driver for a 2-to-4 decoder.
// Walks the enabled channels of a latched mask in ascending order and holds
// each channel for DWELL+1 cycles. It runs continuously, or for a single
// rotation when ONESHOT was set at start. All outputs are registered.
// The FSM state is observable on BUSY, which is high exactly in SCAN.
module decoder_scan_ctrl #(
   parameter int DWELL_W = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               STOP,
   input  logic               ONESHOT,
   input  logic [3:0]         MASK,
   input  logic [DWELL_W-1:0] DWELL,
   output logic               EN,
   output logic               A1,
   output logic               A0,
   output logic               BUSY,
   output logic               WRAP,
   output logic               DONE
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t             state;
   logic [DWELL_W-1:0] cnt;
   logic [1:0]         idx;
   logic [3:0]         mask_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               oneshot_q;

   logic [1:0]         nxt_idx;
   logic [1:0]         cand;
   logic               wrap_evt;
   logic [1:0]         first_idx;
   logic               start_ok;

   // Next enabled channel above idx, wrapping 3->0. The search includes idx
   // itself as the last candidate, so a single-channel mask returns idx.
   always_comb begin
      nxt_idx = idx;
      cand    = idx;
      for (int k = 4; k >= 1; k--) begin
         cand = idx + 2'(k);
         if (mask_q[cand]) nxt_idx = cand;
      end
      wrap_evt = (nxt_idx <= idx);
   end

   // Lowest set bit of the incoming mask selects the first channel at start.
   always_comb begin
      first_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (MASK[k]) first_idx = 2'(k);
      end
      start_ok = START && !STOP && (MASK != 4'd0);
   end

   // Scan FSM with dwell counter; outputs are registered alongside the state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= 2'd0;
         mask_q    <= 4'd0;
         dwell_q   <= '0;
         oneshot_q <= 1'b0;
         EN        <= 1'b0;
         A1        <= 1'b0;
         A0        <= 1'b0;
         BUSY      <= 1'b0;
         WRAP      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         WRAP <= 1'b0;
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               EN   <= 1'b0;
               A1   <= 1'b0;
               A0   <= 1'b0;
               BUSY <= 1'b0;
               if (start_ok) begin
                  mask_q    <= MASK;
                  dwell_q   <= DWELL;
                  oneshot_q <= ONESHOT;
                  idx       <= first_idx;
                  cnt       <= DWELL;
                  state     <= ST_SCAN;
                  EN        <= 1'b1;
                  {A1, A0}  <= first_idx;
                  BUSY      <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (STOP) begin
                  // Abort: no WRAP/DONE on a forced stop.
                  state <= ST_IDLE;
                  EN    <= 1'b0;
                  A1    <= 1'b0;
                  A0    <= 1'b0;
                  BUSY  <= 1'b0;
               end else if (cnt == '0) begin
                  if (wrap_evt && oneshot_q) begin
                     state <= ST_IDLE;
                     EN    <= 1'b0;
                     A1    <= 1'b0;
                     A0    <= 1'b0;
                     BUSY  <= 1'b0;
                     WRAP  <= 1'b1;
                     DONE  <= 1'b1;
                  end else begin
                     idx      <= nxt_idx;
                     {A1, A0} <= nxt_idx;
                     cnt      <= dwell_q;
                     WRAP     <= wrap_evt;
                  end
               end else begin
                  cnt <= cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
